// File: rtl/fft_sequencer_if.sv
// Control bus of the FFT pair sequencer: start/stall requests in,
// AGU stage/pair issue and write/status strobes out.
interface fft_sequencer_if #(
    parameter int N = 32
);
    localparam int LOG2N   = $clog2(N);
    localparam int STAGE_W = $clog2(LOG2N);
    localparam int PAIR_W  = $clog2(N / 2);

    logic               i_start;
    logic               i_stall;
    logic [STAGE_W-1:0] o_stage;
    logic [PAIR_W-1:0]  o_pair_id;
    logic               o_valid;
    logic               o_last_pair;
    logic               o_wr_en;
    logic               o_busy;
    logic               o_done;

    // Controller side: requests an FFT and observes progress.
    modport master (
        output i_start, i_stall,
        input  o_stage, o_pair_id, o_valid, o_last_pair, o_wr_en, o_busy, o_done
    );

    // Sequencer side.
    modport slave (
        input  i_start, i_stall,
        output o_stage, o_pair_id, o_valid, o_last_pair, o_wr_en, o_busy, o_done
    );
endinterface

// File: rtl/fft_sequencer.sv
// FFT butterfly sequencer: walks every stage and pair of an N-point radix-2
// FFT, drains the datapath between stages so the next stage never reads a
// location still waiting to be written, and mirrors each issued pair as a
// memory write strobe PIPE_DEPTH+1 cycles later.
module fft_sequencer #(
    parameter int N          = 32,
    parameter int PIPE_DEPTH = 4
) (
    input logic           i_clk,
    input logic           i_reset,
    fft_sequencer_if.slave bus
);
    localparam int LOG2N   = $clog2(N);
    localparam int STAGE_W = $clog2(LOG2N);
    localparam int PAIR_W  = $clog2(N / 2);
    localparam int CNT_W   = $clog2(PIPE_DEPTH + 2);

    localparam logic [STAGE_W-1:0] LAST_STAGE  = STAGE_W'(LOG2N - 1);
    localparam logic [PAIR_W-1:0]  LAST_PAIR   = PAIR_W'(N / 2 - 1);
    localparam logic [PAIR_W-1:0]  PENULT_PAIR = PAIR_W'(N / 2 - 2);
    localparam logic [CNT_W-1:0]   DRAIN_LOAD  = CNT_W'(PIPE_DEPTH + 1);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              r_state;
    logic [STAGE_W-1:0]  r_stage;
    logic [PAIR_W-1:0]   r_pairId;
    logic                r_valid;
    logic                r_lastPair;
    logic                r_busy;
    logic                r_done;
    logic [CNT_W-1:0]    r_drainCnt;
    logic [PIPE_DEPTH:0] r_wrPipe;

    // Sequencer FSM; every output is computed one edge ahead so it is a flop.
    // pair_id always shows the next pair to issue, valid says whether it goes.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_stage    <= '0;
            r_pairId   <= '0;
            r_valid    <= 1'b0;
            r_lastPair <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_drainCnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.i_start) begin
                        r_state    <= RUN;
                        r_stage    <= '0;
                        r_pairId   <= '0;
                        r_valid    <= !bus.i_stall;
                        r_lastPair <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (r_valid && (r_pairId == LAST_PAIR)) begin
                        r_state    <= DRAIN;
                        r_valid    <= 1'b0;
                        r_lastPair <= 1'b0;
                        r_drainCnt <= DRAIN_LOAD;
                    end else if (r_valid) begin
                        r_pairId   <= r_pairId + PAIR_W'(1);
                        r_valid    <= !bus.i_stall;
                        r_lastPair <= !bus.i_stall && (r_pairId == PENULT_PAIR);
                    end else begin
                        r_valid    <= !bus.i_stall;
                        r_lastPair <= !bus.i_stall && (r_pairId == LAST_PAIR);
                    end
                end
                DRAIN: begin
                    if (r_drainCnt == CNT_ONE) begin
                        r_drainCnt <= '0;
                        r_pairId   <= '0;
                        if (r_stage == LAST_STAGE) begin
                            r_state <= DONE;
                            r_stage <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_stage <= r_stage + STAGE_W'(1);
                            r_valid <= !bus.i_stall;
                        end
                    end else begin
                        r_drainCnt <= r_drainCnt - CNT_ONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Write-strobe delay line models the AGU register plus the datapath; it
    // shifts every cycle so strobes keep flowing through stalls and drains.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wrPipe <= '0;
        end else begin
            r_wrPipe <= {r_wrPipe[PIPE_DEPTH-1:0], r_valid};
        end
    end

    assign bus.o_stage     = r_stage;
    assign bus.o_pair_id   = r_pairId;
    assign bus.o_valid     = r_valid;
    assign bus.o_last_pair = r_lastPair;
    assign bus.o_wr_en     = r_wrPipe[PIPE_DEPTH];
    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;
endmodule
